decode_writeback: RTL and testbench
===================================

// Module: decode_writeback
// PURPOSE
//  Y86-64 pipeline decode stage; sits directly downstream of the fetch stage and consumes its D-register outputs.
//  - Reads the register file, resolves data hazards by forwarding from E/M/W, and drives the E pipeline register.
//  - Hosts the register file, written from the W stage.
//  - Exports d_srcA/d_srcB so the hazard unit can detect load/use stalls.
// PARAMETERS
//  DATA_W  64  datapath width
//  NREGS   15  architectural registers %rax..%r14; id 4'hF = RNONE (no register)
// PORTS
//  clk                  in   1       single clock; all state updates on posedge
//  rst_n                in   1       asynchronous, active-low reset
//  D_icode,D_ifun       in   4,4     instruction from fetch D register
//  D_rA,D_rB            in   4,4     register specifiers (4'hF = none)
//  D_valC,D_valP        in   64,64   constant word / next-PC
//  D_stat               in   3       {INS/ADR,HLT,AOK}
//  E_bubble             in   1       hazard unit: load nop into E this cycle
//  e_dstE,e_valE        in   4,64    execute-stage result (combinational)
//  M_dstE,M_valE        in   4,64    memory-stage ALU result
//  M_dstM,m_valM        in   4,64    memory-stage load result
//  W_dstE,W_valE        in   4,64    writeback port E; also regfile write
//  W_dstM,W_valM        in   4,64    writeback port M; also regfile write
//  d_srcA,d_srcB        out  4,4     combinational source ids to hazard unit
//  E_icode,E_ifun       out  4,4     E register
//  E_valC,E_valA,E_valB out  64x3    E register operands
//  E_dstE,E_dstM        out  4,4     E register destinations
//  E_srcA,E_srcB        out  4,4     E register source ids
//  E_stat               out  3       E register status
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All 15 registers cleared to 0.
//   - E register = bubble: icode=1 (nop), ifun=0, valC/valA/valB=0, dst*/src*=F, stat=3'b001.
//  Decode: combinational from D_icode
//   - srcA: rA for cmov(2)/rmmov(4)/OPq(6)/push(A); 4 (%rsp) for pop(B)/ret(9); else F.
//   - srcB: rB for OPq/rmmov/mrmov(5); 4 for push/pop/call(8)/ret; else F.
//   - dstE: rB for cmov/irmov(3)/OPq; 4 for push/pop/call/ret; else F.
//   - dstM: rA for mrmov/pop; else F.
//  Operand select for valA, first match wins:
//   - call/jXX(7): D_valP.
//   - e_dstE: e_valE.
//   - M_dstM: m_valM.
//   - M_dstE: M_valE.
//   - W_dstM: W_valM.
//   - W_dstE: W_valE.
//   - otherwise the regfile read.
//  Operand select for valB: same chain without the valP term.
//  Any source or dst id of F never matches and reads 0.
//  Register file
//   - Reads are asynchronous.
//   - Writes on posedge when W_dstE!=F or W_dstM!=F.
//   - W_dstE==W_dstM (popq %rsp): W_valM wins.
//   - Same-cycle read of the register being written returns the old array value; the W forwarding terms supply the new one.
//  E register, posedge
//   - E_bubble=1: load the reset bubble pattern.
//   - Otherwise: load the decoded fields; latency 1 cycle.
//   - E never stalls.
//   - Regfile writes proceed regardless of E_bubble.
//   - rst_n low mid-cycle overrides all and takes effect immediately.
//  Invalid D_icode (>B): pass through with srcs/dsts=F; D_stat is carried unchanged (fetch already flags INS).
// STRUCTURE
//  Shared package y86_pkg:
//   - icode constants I_HALT..I_POPQ.
//   - RNONE=4'hF, RRSP=4'h4.
//   - Stat codes S_AOK=3'b001, S_HLT=3'b010, S_ERR=3'b100.
//  Sub-module y86_regfile:
//   - 15x64 array, 2 async read ports, 2 sync write ports with M-priority, async clear.
//  The top level holds the decode table, the forwarding mux, and the E register.
// TESTING
//  - Reset: assert rst_n=0 mid-run -> E_icode=1, E_dstE=F, E_stat=001 immediately; regfile reads 0.
//  - irmovq: D_icode=3, rB=2, valC=0x55 -> next cycle E_dstE=2, E_valC=0x55, E_srcA=F, E_srcB=F.
//  - Writeback then read:
//    - Drive W_dstE=3, W_valE=0x1234 for 1 clk, then OPq rA=3 with no forwarding -> E_valA=0x1234.
//    - OPq rA=3 decoded in the write cycle -> E_valA=0x1234 via W forwarding.
//  - Forward priority:
//    - e_dstE=M_dstE=W_dstE=1 with values 0xA/0xB/0xC; OPq rA=1 -> E_valA=0xA.
//    - Drop e_dstE to F -> E_valA=0xB.
//  - Load forward and dual write:
//    - M_dstM=2, m_valM=0x77 -> E_valB=0x77 for OPq rB=2.
//    - W_dstE=W_dstM=4 with valE=0x10, valM=0x20 -> %rsp reads 0x20.
//  - call and bubble:
//    - D_icode=8, valP=0x40 -> E_valA=0x40, E_srcB=4, E_dstE=4.
//    - Same inputs with E_bubble=1 -> E holds nop pattern while the regfile write still occurs.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids, status codes.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] S_AOK = 3'b001;
  localparam logic [2:0] S_HLT = 3'b010;
  localparam logic [2:0] S_ERR = 3'b100;

  // A register id of RNONE never matches anything, including another RNONE.
  function automatic logic id_match(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: async reads, two sync write ports (M port wins on
// a same-register collision), async clear.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m
);

  logic [DATA_W-1:0] regs [NREGS];

  // Write ports; the M write is issued last so it overrides E (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  // Asynchronous read ports; RNONE reads as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (src_a != RNONE) rd_a = regs[src_a];
    if (src_b != RNONE) rd_b = regs[src_b];
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode stage: decode table, register-file read with E/M/W
// forwarding, and the E pipeline register. Hosts the register file.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [2:0]        D_stat,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [2:0]        E_stat
);

  logic [3:0]        d_dstE;
  logic [3:0]        d_dstM;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;

  y86_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .src_a(d_srcA),
    .src_b(d_srcB),
    .rd_a (rf_a),
    .rd_b (rf_b),
    .dst_e(W_dstE),
    .val_e(W_valE),
    .dst_m(W_dstM),
    .val_m(W_valM)
  );

  // Source/destination register ids from the instruction code.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin
        d_srcA = D_rA;
        d_dstE = D_rB;
      end
      I_IRMOVQ: d_dstE = D_rB;
      I_RMMOVQ: begin
        d_srcA = D_rA;
        d_srcB = D_rB;
      end
      I_MRMOVQ: begin
        d_srcB = D_rB;
        d_dstM = D_rA;
      end
      I_OPQ: begin
        d_srcA = D_rA;
        d_srcB = D_rB;
        d_dstE = D_rB;
      end
      I_CALL: begin
        d_srcB = RRSP;
        d_dstE = RRSP;
      end
      I_RET: begin
        d_srcA = RRSP;
        d_srcB = RRSP;
        d_dstE = RRSP;
      end
      I_PUSHQ: begin
        d_srcA = D_rA;
        d_srcB = RRSP;
        d_dstE = RRSP;
      end
      I_POPQ: begin
        d_srcA = RRSP;
        d_srcB = RRSP;
        d_dstE = RRSP;
        d_dstM = D_rA;
      end
      default: ;
    endcase
  end

  // Operand selection: youngest producer first, regfile last.
  always_comb begin
    d_valA = rf_a;
    if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
    else if (id_match(d_srcA, e_dstE))         d_valA = e_valE;
    else if (id_match(d_srcA, M_dstM))         d_valA = m_valM;
    else if (id_match(d_srcA, M_dstE))         d_valA = M_valE;
    else if (id_match(d_srcA, W_dstM))         d_valA = W_valM;
    else if (id_match(d_srcA, W_dstE))         d_valA = W_valE;

    d_valB = rf_b;
    if      (id_match(d_srcB, e_dstE)) d_valB = e_valE;
    else if (id_match(d_srcB, M_dstM)) d_valB = m_valM;
    else if (id_match(d_srcB, M_dstE)) d_valB = M_valE;
    else if (id_match(d_srcB, W_dstM)) d_valB = W_valM;
    else if (id_match(d_srcB, W_dstE)) d_valB = W_valE;
  end

  // E pipeline register: reset and bubble both load the nop pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_stat  <= S_AOK;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_stat  <= D_stat;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Testbench for decode_writeback: expected E-register contents are queued
// when a D instruction is driven and compared one cycle later.
module tb_decode_writeback;

  logic        clk;
  logic        rst_n;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [2:0]  D_stat;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [2:0]  E_stat;

  typedef struct {
    string       tag;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [2:0]  stat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  decode_writeback #(
    .DATA_W(64),
    .NREGS (15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D_icode (D_icode),
    .D_ifun  (D_ifun),
    .D_rA    (D_rA),
    .D_rB    (D_rB),
    .D_valC  (D_valC),
    .D_valP  (D_valP),
    .D_stat  (D_stat),
    .E_bubble(E_bubble),
    .e_dstE  (e_dstE),
    .e_valE  (e_valE),
    .M_dstE  (M_dstE),
    .M_valE  (M_valE),
    .M_dstM  (M_dstM),
    .m_valM  (m_valM),
    .W_dstE  (W_dstE),
    .W_valE  (W_valE),
    .W_dstM  (W_dstM),
    .W_valM  (W_valM),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_ifun  (E_ifun),
    .E_valC  (E_valC),
    .E_valA  (E_valA),
    .E_valB  (E_valB),
    .E_dstE  (E_dstE),
    .E_dstM  (E_dstM),
    .E_srcA  (E_srcA),
    .E_srcB  (E_srcB),
    .E_stat  (E_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = '0; D_valP = '0; D_stat = 3'b001; E_bubble = 1'b0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
    D_icode = icode; D_ifun = ifun; D_rA = ra; D_rB = rb;
    D_valC = valc; D_valP = valp;
  endtask

  task automatic expect_e(input string tag, input logic [3:0] icode, input logic [3:0] ifun,
                          input logic [63:0] valc, input logic [63:0] vala,
                          input logic [63:0] valb, input logic [3:0] dste,
                          input logic [3:0] dstm, input logic [3:0] srca,
                          input logic [3:0] srcb, input logic [2:0] stat);
    exp_t e;
    e.tag = tag; e.icode = icode; e.ifun = ifun; e.valC = valc; e.valA = vala;
    e.valB = valb; e.dstE = dste; e.dstM = dstm; e.srcA = srca; e.srcB = srcb;
    e.stat = stat;
    sb.push_back(e);
  endtask

  task automatic expect_nop(input string tag);
    expect_e(tag, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b001);
  endtask

  // One clock: sample #1 after the edge and compare against the queue head.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".icode"}, E_icode, e.icode);
    check({e.tag, ".ifun"},  E_ifun,  e.ifun);
    check({e.tag, ".valC"},  E_valC,  e.valC);
    check({e.tag, ".valA"},  E_valA,  e.valA);
    check({e.tag, ".valB"},  E_valB,  e.valB);
    check({e.tag, ".dstE"},  E_dstE,  e.dstE);
    check({e.tag, ".dstM"},  E_dstM,  e.dstM);
    check({e.tag, ".srcA"},  E_srcA,  e.srcA);
    check({e.tag, ".srcB"},  E_srcB,  e.srcB);
    check({e.tag, ".stat"},  E_stat,  e.stat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    check("rst.icode", E_icode, 64'h1);
    check("rst.dstE",  E_dstE,  64'hF);
    check("rst.srcA",  E_srcA,  64'hF);
    check("rst.stat",  E_stat,  64'h1);
    rst_n = 1'b1;

    // irmovq $0x55, %rdx
    set_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h55, 64'h5F);
    #1;
    check("irmov.d_srcA", d_srcA, 64'hF);
    check("irmov.d_srcB", d_srcB, 64'hF);
    expect_e("irmov", 4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF, 3'b001);
    tick();

    // OPq rA=3 decoded in the same cycle W writes r3: W forwarding
    clear_inputs();
    W_dstE = 4'h3; W_valE = 64'h1234;
    set_d(4'h6, 4'h1, 4'h3, 4'h2, 64'h0, 64'h61);
    #1;
    check("opq.d_srcA", d_srcA, 64'h3);
    check("opq.d_srcB", d_srcB, 64'h2);
    expect_e("wfwd", 4'h6, 4'h1, 64'h0, 64'h1234, 64'h0, 4'h2, 4'hF, 4'h3, 4'h2, 3'b001);
    tick();

    // Same OPq after the write: value comes from the array
    clear_inputs();
    set_d(4'h6, 4'h1, 4'h3, 4'h2, 64'h0, 64'h61);
    expect_e("wb_read", 4'h6, 4'h1, 64'h0, 64'h1234, 64'h0, 4'h2, 4'hF, 4'h3, 4'h2, 3'b001);
    tick();

    // Forward priority e > M > W on r1
    clear_inputs();
    e_dstE = 4'h1; e_valE = 64'hA;
    M_dstE = 4'h1; M_valE = 64'hB;
    W_dstE = 4'h1; W_valE = 64'hC;
    set_d(4'h6, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
    expect_e("fwd_e", 4'h6, 4'h0, 64'h0, 64'hA, 64'h1234, 4'h3, 4'hF, 4'h1, 4'h3, 3'b001);
    tick();
    e_dstE = 4'hF;
    expect_e("fwd_M", 4'h6, 4'h0, 64'h0, 64'hB, 64'h1234, 4'h3, 4'hF, 4'h1, 4'h3, 3'b001);
    tick();
    M_dstE = 4'hF; W_valE = 64'hD;
    expect_e("fwd_W", 4'h6, 4'h0, 64'h0, 64'hD, 64'h1234, 4'h3, 4'hF, 4'h1, 4'h3, 3'b001);
    tick();
    clear_inputs();
    set_d(4'h6, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
    expect_e("r1_read", 4'h6, 4'h0, 64'h0, 64'hD, 64'h1234, 4'h3, 4'hF, 4'h1, 4'h3, 3'b001);
    tick();

    // Load forward beats M ALU forward for the same register
    clear_inputs();
    M_dstM = 4'h2; m_valM = 64'h77;
    M_dstE = 4'h2; M_valE = 64'h99;
    set_d(4'h6, 4'h0, 4'h3, 4'h2, 64'h0, 64'h0);
    expect_e("ldfwd", 4'h6, 4'h0, 64'h0, 64'h1234, 64'h77, 4'h2, 4'hF, 4'h3, 4'h2, 3'b001);
    tick();

    // Dual write to %rsp: M port wins, both in forwarding and in the array
    clear_inputs();
    W_dstE = 4'h4; W_valE = 64'h10;
    W_dstM = 4'h4; W_valM = 64'h20;
    set_d(4'h6, 4'h0, 4'h4, 4'h4, 64'h0, 64'h0);
    expect_e("dual_fwd", 4'h6, 4'h0, 64'h0, 64'h20, 64'h20, 4'h4, 4'hF, 4'h4, 4'h4, 3'b001);
    tick();
    clear_inputs();
    set_d(4'h6, 4'h0, 4'h4, 4'h4, 64'h0, 64'h0);
    expect_e("dual_read", 4'h6, 4'h0, 64'h0, 64'h20, 64'h20, 4'h4, 4'hF, 4'h4, 4'h4, 3'b001);
    tick();

    // call: valA = valP, %rsp source/destination
    clear_inputs();
    set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40);
    #1;
    check("call.d_srcB", d_srcB, 64'h4);
    expect_e("call", 4'h8, 4'h0, 64'h100, 64'h40, 64'h20, 4'h4, 4'hF, 4'hF, 4'h4, 3'b001);
    tick();

    // Same call bubbled while W writes r5
    E_bubble = 1'b1;
    W_dstE = 4'h5; W_valE = 64'h5555;
    expect_nop("bubble");
    tick();
    clear_inputs();
    set_d(4'h6, 4'h0, 4'h5, 4'hF, 64'h0, 64'h0);
    expect_e("bubble_wr", 4'h6, 4'h0, 64'h0, 64'h5555, 64'h0, 4'hF, 4'hF, 4'h5, 4'hF, 3'b001);
    tick();

    // Decode table sweep; regs: r1=D r3=1234 r4=20 r5=5555, others 0
    clear_inputs();
    set_d(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h0);
    expect_e("pushq", 4'hA, 4'h0, 64'h0, 64'h1234, 64'h20, 4'h4, 4'hF, 4'h3, 4'h4, 3'b001);
    tick();
    set_d(4'hB, 4'h0, 4'h6, 4'hF, 64'h0, 64'h0);
    expect_e("popq", 4'hB, 4'h0, 64'h0, 64'h20, 64'h20, 4'h4, 4'h6, 4'h4, 4'h4, 3'b001);
    tick();
    set_d(4'h5, 4'h0, 4'h7, 4'h3, 64'h8, 64'h0);
    expect_e("mrmovq", 4'h5, 4'h0, 64'h8, 64'h0, 64'h1234, 4'hF, 4'h7, 4'hF, 4'h3, 3'b001);
    tick();
    set_d(4'h4, 4'h0, 4'h1, 4'h3, 64'h10, 64'h0);
    expect_e("rmmovq", 4'h4, 4'h0, 64'h10, 64'hD, 64'h1234, 4'hF, 4'hF, 4'h1, 4'h3, 3'b001);
    tick();
    set_d(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    expect_e("ret", 4'h9, 4'h0, 64'h0, 64'h20, 64'h20, 4'h4, 4'hF, 4'h4, 4'h4, 3'b001);
    tick();
    set_d(4'h7, 4'h3, 4'hF, 4'hF, 64'h200, 64'h88);
    expect_e("jxx", 4'h7, 4'h3, 64'h200, 64'h88, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b001);
    tick();
    set_d(4'h2, 4'h1, 4'h3, 4'h6, 64'h0, 64'h0);
    expect_e("cmov", 4'h2, 4'h1, 64'h0, 64'h1234, 64'h0, 4'h6, 4'hF, 4'h3, 4'hF, 3'b001);
    tick();
    set_d(4'hC, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
    D_stat = 3'b100;
    expect_e("invalid", 4'hC, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b100);
    tick();
    set_d(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    D_stat = 3'b010;
    expect_e("halt", 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'b010);
    tick();

    // Mid-cycle asynchronous reset, then the cleared regfile reads 0
    clear_inputs();
    set_d(4'h6, 4'h0, 4'h1, 4'h4, 64'h0, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.icode", E_icode, 64'h1);
    check("arst.dstE",  E_dstE,  64'hF);
    check("arst.stat",  E_stat,  64'h1);
    #2;
    rst_n = 1'b1;
    expect_e("arst_read", 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'hF, 4'h1, 4'h4, 3'b001);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
